// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared constants and types for the instruction fetch stage
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int          FETCH_FIFO_DEPTH = 2;
  localparam int          FETCH_CNT_W      = $clog2(FETCH_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : small in-order FIFO with flush, used for responses and issued PCs
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only legal when a pop frees a slot that cycle
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !(rst || flush))
      mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : credit-based instruction fetch with redirect drop and IF/ID reg
// Optional FETCH_PERF_CNT_EN adds stall/flush counters. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FetchStallCnt,
  output logic [31:0] FetchFlushCnt
`endif
);

  fetch_state_t           state;
  fetch_state_t           state_next;
  logic [31:0]            pcf;
  logic [FETCH_CNT_W-1:0] drop_cnt;
  logic [FETCH_CNT_W-1:0] drop_next;
  logic [FETCH_CNT_W-1:0] out_cnt;
  logic [FETCH_CNT_W-1:0] fifo_cnt;
  logic [31:0]            issued_pc;
  logic                   credit_ok;
  logic                   accept;
  logic                   resp_keep;
  logic                   resp_drop;
  logic                   fifo_empty;
  logic                   can_load;
  logic                   rf_push;
  logic                   rf_pop;
  fetch_entry_t           incoming;
  fetch_entry_t           fifo_head;
  fetch_entry_t           load_entry;

  assign credit_ok  = ({1'b0, out_cnt} + {1'b0, fifo_cnt}) < (FETCH_CNT_W+1)'(FETCH_FIFO_DEPTH);
  assign accept     = imem_req && imem_ready;
  assign resp_keep  = imem_rvalid && !PCSrcE && (drop_cnt == '0);
  assign resp_drop  = imem_rvalid && !resp_keep;
  assign fifo_empty = (fifo_cnt == '0);
  assign incoming   = '{instr: imem_rdata, pc: issued_pc};

  // With an empty FIFO the arriving response bypasses straight into IF/ID
  assign load_entry = fifo_empty ? incoming : fifo_head;
  assign can_load   = !PCSrcE && !FlushD && !StallD && (!fifo_empty || resp_keep);
  assign rf_pop     = can_load && !fifo_empty;
  assign rf_push    = resp_keep && !(can_load && fifo_empty);

  // Issued-address queue: one entry per request still awaiting its response
  fetch_fifo #(.WIDTH(32), .DEPTH(FETCH_FIFO_DEPTH)) u_addr_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (accept),
    .push_data (pcf),
    .pop       (imem_rvalid),
    .head      (issued_pc),
    .count     (out_cnt)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FETCH_FIFO_DEPTH)) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (PCSrcE),
    .push      (rf_push),
    .push_data (incoming),
    .pop       (rf_pop),
    .head      (fifo_head),
    .count     (fifo_cnt)
  );

  always_comb begin
    drop_next = drop_cnt;
    if (PCSrcE)
      drop_next = out_cnt - FETCH_CNT_W'(imem_rvalid);
    else if (resp_drop)
      drop_next = drop_cnt - FETCH_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      drop_cnt <= '0;
      pcf      <= RESET_PC;
    end else begin
      state    <= state_next;
      drop_cnt <= drop_next;
      if (PCSrcE)
        pcf <= PCTargetE;
      else if (accept)
        pcf <= pcf + 32'd4;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     if (PCSrcE && (drop_next != '0)) state_next = DROP;
      DROP:    state_next = (drop_next == '0) ? RUN : DROP;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    imem_req  = !rst && !StallF && !PCSrcE && (state != BOOT) && credit_ok;
    imem_addr = pcf;
  end

  always_ff @(posedge clk) begin
    if (rst || PCSrcE || FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      if (can_load) begin
        InstrD   <= load_entry.instr;
        PCD      <= load_entry.pc;
        PCPlus4D <= load_entry.pc + 32'd4;
        ValidD   <= 1'b1;
      end else begin
        InstrD   <= NOP_INSTR;
        PCD      <= '0;
        PCPlus4D <= '0;
        ValidD   <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      FetchStallCnt <= '0;
      FetchFlushCnt <= '0;
    end else begin
      FetchStallCnt <= FetchStallCnt + 32'(StallF);
      FetchFlushCnt <= FetchFlushCnt + 32'(resp_drop) + (PCSrcE ? 32'(fifo_cnt) : 32'd0);
    end
  end
`endif

endmodule

`default_nettype wire
